// File: rtl/keypad_scanner.sv
// 4x4 active-low key matrix scanner: strobes rows, synchronizes columns, debounces whole
// frames and emits one code/valid pulse per accepted single-key press.
module keypad_scanner #(
   parameter int unsigned ROW_DWELL_BITS  = 2,
   parameter int unsigned DEBOUNCE_FRAMES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col_n,
   output logic [3:0] row_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   typedef enum logic [1:0] {StIdle, StDebounce, StPressed, StRelease} state_e;

   localparam logic [3:0] DfCnt = 4'(DEBOUNCE_FRAMES);

   logic [3:0]                sync1_q, sync2_q;
   logic [ROW_DWELL_BITS-1:0] pre_q;
   logic [1:0]                row_q;
   logic [11:0]               snap_q;
   logic                      sample, frame_end;

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d, cnt_inc;
   logic [3:0] cand_q, cand_d;
   logic [3:0] key_code_q, key_code_d;
   logic       key_valid_q, key_valid_d;
   logic       key_held_q, key_held_d;

   logic [15:0] pressed;
   logic [4:0]  nkeys;
   logic [3:0]  frame_code;
   logic        frame_none, frame_single;

   assign sample    = &pre_q;
   assign frame_end = sample && (row_q == 2'd3);
   assign row_n     = ~(4'b0001 << row_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 4'b1111;
         sync2_q <= 4'b1111;
         pre_q   <= '0;
         row_q   <= 2'd0;
         snap_q  <= '1;
      end else begin
         sync1_q <= col_n;
         sync2_q <= sync1_q;
         pre_q   <= pre_q + 1'b1;
         if (sample) begin
            row_q <= row_q + 2'd1;
            // Row 3 is never stored: at frame end it is taken live from the synchronizer.
            case (row_q)
               2'd0:    snap_q[3:0]  <= sync2_q;
               2'd1:    snap_q[7:4]  <= sync2_q;
               2'd2:    snap_q[11:8] <= sync2_q;
               default: ;
            endcase
         end
      end
   end

   assign pressed = ~{sync2_q, snap_q};

   always_comb begin
      nkeys      = 5'd0;
      frame_code = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (pressed[i]) begin
            nkeys      = nkeys + 5'd1;
            frame_code = 4'(i);
         end
      end
      frame_none   = (nkeys == 5'd0);
      frame_single = (nkeys == 5'd1);
   end

   assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= 4'd0;
         cand_q      <= 4'd0;
         key_code_q  <= 4'd0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cand_q      <= cand_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cand_d      = cand_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      if (frame_end) begin
         unique case (state_q)
            StIdle: begin
               if (frame_single) begin
                  cand_d = frame_code;
                  if (DfCnt == 4'd1) begin
                     key_code_d  = frame_code;
                     key_valid_d = 1'b1;
                     key_held_d  = 1'b1;
                     cnt_d       = 4'd0;
                     state_d     = StPressed;
                  end else begin
                     cnt_d   = 4'd1;
                     state_d = StDebounce;
                  end
               end
            end
            StDebounce: begin
               if (frame_single && frame_code == cand_q) begin
                  if (cnt_inc >= DfCnt) begin
                     key_code_d  = cand_q;
                     key_valid_d = 1'b1;
                     key_held_d  = 1'b1;
                     cnt_d       = 4'd0;
                     state_d     = StPressed;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else if (frame_single) begin
                  cand_d = frame_code;
                  cnt_d  = 4'd1;
               end else begin
                  cnt_d   = 4'd0;
                  state_d = StIdle;
               end
            end
            StPressed: begin
               if (frame_none) begin
                  if (DfCnt == 4'd1) begin
                     key_held_d = 1'b0;
                     cnt_d      = 4'd0;
                     state_d    = StIdle;
                  end else begin
                     cnt_d   = 4'd1;
                     state_d = StRelease;
                  end
               end else begin
                  cnt_d = 4'd0;
               end
            end
            StRelease: begin
               if (frame_none) begin
                  if (cnt_inc >= DfCnt) begin
                     key_held_d = 1'b0;
                     cnt_d      = 4'd0;
                     state_d    = StIdle;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  // Bounce during release: fall back to held without a new pulse.
                  cnt_d   = 4'd0;
                  state_d = StPressed;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: key matrix model drives col_n from row_n; expected key codes are
// queued as presses are driven and compared whenever key_valid pulses.
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] col_n;
   logic [3:0] row_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [15:0] keys = 16'h0000;
   int          exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          mon_exp;

   keypad_scanner #(
      .ROW_DWELL_BITS (2),
      .DEBOUNCE_FRAMES(3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .col_n    (col_n),
      .row_n    (row_n),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_held (key_held)
   );

   always #5 clk = ~clk;

   // Column (c) reads low only while a row with a pressed key in column c is strobed.
   always_comb begin
      col_n = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && key_valid === 1'b1) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL pulse: key_valid with key_code=%0d, required no pulse", key_code);
         end else begin
            mon_exp = exp_q.pop_front();
            if (key_code !== mon_exp[3:0]) begin
               miscompares++;
               $display("FAIL pulse_code: key_code=%0d, required %0d", key_code, mon_exp);
            end
         end
      end
   end

   task automatic run_frames(input int n);
      repeat (16 * n) @(negedge clk);
   endtask

   // Leaves the bench on the negedge that opens frame 1 (row 0, prescaler 0).
   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b1;
      keys = 16'h0000;
      repeat (2) @(negedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL pending: %0d expected pulses never seen, required 0", exp_q.size());
      end
      exp_q.delete();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [3:0] er;
      do_reset();
      keys = 16'h0040;
      run_frames(2);
      exp_q.push_back(6);
      run_frames(1);
      vectors++;
      if (key_code !== 4'd6) begin
         miscompares++;
         $display("FAIL reset_pre_code: key_code=%0d, required 6", key_code);
      end
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      vectors++;
      if ({row_n, key_code, key_valid, key_held} !== {4'b1110, 4'd0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_async: row_n=%b code=%0d valid=%b held=%b, required 1110/0/0/0",
                  row_n, key_code, key_valid, key_held);
      end
      keys = 16'h0000;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k <= 16; k++) begin
         if (k % 4 == 0) begin
            er = 4'b1111 ^ (4'b0001 << ((k / 4) % 4));
            vectors++;
            if (row_n !== er) begin
               miscompares++;
               $display("FAIL row_scan: after %0d clocks row_n=%b, required %b", k, row_n, er);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_press();
      do_reset();
      keys = 16'h0200;
      run_frames(2);
      vectors++;
      if (key_valid !== 1'b0 || key_held !== 1'b0) begin
         miscompares++;
         $display("FAIL press_early: valid=%b held=%b, required 0/0", key_valid, key_held);
      end
      exp_q.push_back(9);
      run_frames(1);
      vectors++;
      if ({key_valid, key_held, key_code} !== {1'b1, 1'b1, 4'd9}) begin
         miscompares++;
         $display("FAIL press_accept: valid=%b held=%b code=%0d, required 1/1/9",
                  key_valid, key_held, key_code);
      end
      @(negedge clk);
      vectors++;
      if (key_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL press_width: key_valid=%b one cycle later, required 0", key_valid);
      end
      run_frames(20);
      vectors++;
      if (key_held !== 1'b1 || key_code !== 4'd9) begin
         miscompares++;
         $display("FAIL press_hold: held=%b code=%0d, required 1/9", key_held, key_code);
      end
   endtask

   task automatic test_bounce();
      do_reset();
      keys = 16'h0200;
      run_frames(2);
      keys = 16'h0000;
      run_frames(1);
      keys = 16'h0200;
      run_frames(2);
      vectors++;
      if (key_held !== 1'b0) begin
         miscompares++;
         $display("FAIL bounce_early: key_held=%b, required 0", key_held);
      end
      exp_q.push_back(9);
      run_frames(1);
      vectors++;
      if (key_valid !== 1'b1 || key_code !== 4'd9) begin
         miscompares++;
         $display("FAIL bounce_accept: valid=%b code=%0d, required 1/9", key_valid, key_code);
      end
   endtask

   task automatic test_multi();
      do_reset();
      keys = 16'h0021;
      run_frames(10);
      vectors++;
      if (key_held !== 1'b0) begin
         miscompares++;
         $display("FAIL multi_reject: key_held=%b, required 0", key_held);
      end
      keys = 16'h0001;
      exp_q.push_back(0);
      run_frames(3);
      keys = 16'h0021;
      run_frames(5);
      vectors++;
      if (key_held !== 1'b1 || key_code !== 4'd0) begin
         miscompares++;
         $display("FAIL multi_hold: held=%b code=%0d, required 1/0", key_held, key_code);
      end
      keys = 16'h0020;
      run_frames(5);
      vectors++;
      if (key_held !== 1'b1 || key_code !== 4'd0) begin
         miscompares++;
         $display("FAIL multi_swap: held=%b code=%0d, required 1/0", key_held, key_code);
      end
      keys = 16'h0000;
      run_frames(3);
      vectors++;
      if (key_held !== 1'b0) begin
         miscompares++;
         $display("FAIL multi_release: key_held=%b, required 0", key_held);
      end
   endtask

   task automatic test_release();
      do_reset();
      keys = 16'h0200;
      exp_q.push_back(9);
      run_frames(3);
      keys = 16'h0000;
      run_frames(2);
      vectors++;
      if (key_held !== 1'b1) begin
         miscompares++;
         $display("FAIL release_two: key_held=%b after 2 empty frames, required 1", key_held);
      end
      keys = 16'h0200;
      run_frames(1);
      vectors++;
      if (key_held !== 1'b1 || key_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL release_bounce: held=%b valid=%b, required 1/0", key_held, key_valid);
      end
      keys = 16'h0000;
      run_frames(2);
      vectors++;
      if (key_held !== 1'b1) begin
         miscompares++;
         $display("FAIL release_partial: key_held=%b, required 1", key_held);
      end
      run_frames(1);
      vectors++;
      if (key_held !== 1'b0) begin
         miscompares++;
         $display("FAIL release_full: key_held=%b after 3 empty frames, required 0", key_held);
      end
      keys = 16'h0200;
      exp_q.push_back(9);
      run_frames(3);
      vectors++;
      if (key_valid !== 1'b1 || key_code !== 4'd9) begin
         miscompares++;
         $display("FAIL release_repress: valid=%b code=%0d, required 1/9", key_valid, key_code);
      end
   endtask

   task automatic test_reset_debounce();
      do_reset();
      keys = 16'h0200;
      run_frames(2);
      repeat (5) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (key_valid !== 1'b0 || key_held !== 1'b0 || row_n !== 4'b1110) begin
         miscompares++;
         $display("FAIL rstdb_async: valid=%b held=%b row_n=%b, required 0/0/1110",
                  key_valid, key_held, row_n);
      end
      @(negedge clk);
      rst = 1'b0;
      run_frames(2);
      vectors++;
      if (key_held !== 1'b0) begin
         miscompares++;
         $display("FAIL rstdb_early: key_held=%b after 2 frames, required 0", key_held);
      end
      exp_q.push_back(9);
      run_frames(1);
      vectors++;
      if (key_valid !== 1'b1 || key_code !== 4'd9) begin
         miscompares++;
         $display("FAIL rstdb_accept: valid=%b code=%0d, required 1/9", key_valid, key_code);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_press();
      test_bounce();
      test_multi();
      test_release();
      test_reset_debounce();
      run_frames(1);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL pending_end: %0d expected pulses never seen, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
